// File: rtl/laser_error_frontend.sv
// Laser power loop sensing front end: serial ADC readout, 2^AVG_LOG2 sample
// averaging, and setpoint-minus-mean error saturated to a 9-bit signed word.
module laser_error_frontend #(
   parameter int unsigned ADC_BITS = 12,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADC_BITS-1:0] setpoint,
   input  logic                adc_sdo,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   output logic signed [8:0]   error_output,
   output logic                error_valid,
   output logic                sat,
   output logic                busy
);

   localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned BIT_W = $clog2(ADC_BITS + 1);
   localparam int unsigned SMP_W = AVG_LOG2 + 1;
   localparam int unsigned N_SMP = 1 << AVG_LOG2;
   localparam int unsigned DIF_W = ADC_BITS + 1;

   localparam logic signed [DIF_W-1:0] POS_LIM = DIF_W'(255);
   localparam logic signed [DIF_W-1:0] NEG_LIM = DIF_W'(-256);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP,
      CALC
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt, div_nxt;
   logic                phase, phase_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_nxt;
   logic [SMP_W-1:0]    smp_cnt, smp_nxt;
   logic [ADC_BITS-1:0] shreg, sh_nxt;
   logic [ACC_W-1:0]    acc, acc_nxt;
   logic [ADC_BITS-1:0] sp_q, sp_nxt;
   logic signed [8:0]   err_nxt;
   logic                sat_nxt, valid_nxt, busy_nxt, cs_n_nxt, sclk_nxt;
   logic                div_last;
   logic [ADC_BITS-1:0] mean;
   logic signed [DIF_W-1:0] diff;

   // State and datapath registers; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         div_cnt      <= '0;
         phase        <= 1'b0;
         bit_cnt      <= '0;
         smp_cnt      <= '0;
         shreg        <= '0;
         acc          <= '0;
         sp_q         <= '0;
         error_output <= '0;
         sat          <= 1'b0;
         error_valid  <= 1'b0;
         busy         <= 1'b0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b0;
      end else begin
         state        <= state_nxt;
         div_cnt      <= div_nxt;
         phase        <= phase_nxt;
         bit_cnt      <= bit_nxt;
         smp_cnt      <= smp_nxt;
         shreg        <= sh_nxt;
         acc          <= acc_nxt;
         sp_q         <= sp_nxt;
         error_output <= err_nxt;
         sat          <= sat_nxt;
         error_valid  <= valid_nxt;
         busy         <= busy_nxt;
         adc_cs_n     <= cs_n_nxt;
         adc_sclk     <= sclk_nxt;
      end
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      phase_nxt = phase;
      bit_nxt   = bit_cnt;
      smp_nxt   = smp_cnt;
      sh_nxt    = shreg;
      acc_nxt   = acc;
      sp_nxt    = sp_q;
      err_nxt   = error_output;
      sat_nxt   = sat;
      valid_nxt = 1'b0;
      div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
      mean      = ADC_BITS'(acc >> AVG_LOG2);
      diff      = $signed({1'b0, sp_q}) - $signed({1'b0, mean});

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETUP;
               sp_nxt    = setpoint;
               acc_nxt   = '0;
               smp_nxt   = '0;
               div_nxt   = '0;
            end
         end
         SETUP: begin
            if (div_last) begin
               state_nxt = SHIFT;
               div_nxt   = '0;
               phase_nxt = 1'b0;
               bit_nxt   = '0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (!div_last) begin
               div_nxt = div_cnt + 1'b1;
            end else begin
               div_nxt = '0;
               if (!phase) begin
                  // sclk rises on this edge: sample the ADC bit now
                  phase_nxt = 1'b1;
                  sh_nxt    = {shreg[ADC_BITS-2:0], adc_sdo};
               end else if (bit_cnt == BIT_W'(ADC_BITS - 1)) begin
                  phase_nxt = 1'b0;
                  state_nxt = GAP;
                  acc_nxt   = acc + ACC_W'(shreg);
                  smp_nxt   = smp_cnt + 1'b1;
               end else begin
                  phase_nxt = 1'b0;
                  bit_nxt   = bit_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            if (div_last) begin
               div_nxt   = '0;
               state_nxt = (smp_cnt < SMP_W'(N_SMP)) ? SETUP : CALC;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         CALC: begin
            valid_nxt = 1'b1;
            state_nxt = IDLE;
            if (diff > POS_LIM) begin
               err_nxt = 9'sd255;
               sat_nxt = 1'b1;
            end else if (diff < NEG_LIM) begin
               err_nxt = -9'sd256;
               sat_nxt = 1'b1;
            end else begin
               err_nxt = diff[8:0];
               sat_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // busy covers the strobe cycle, hence the CALC term
      busy_nxt = (state_nxt != IDLE) || (state == CALC);
      cs_n_nxt = !((state_nxt == SETUP) || (state_nxt == SHIFT));
      sclk_nxt = (state_nxt == SHIFT) && phase_nxt;
   end

endmodule

// File: tb/tb_laser_error_frontend.sv
// Self-checking bench for laser_error_frontend: serial ADC model, arithmetic
// reference of the averaged/saturated error, latency and framing checks.
module tb_laser_error_frontend;

   localparam int ADC_BITS = 12;
   localparam int CLK_DIV  = 4;
   localparam int AVG_LOG2 = 2;
   localparam int NS       = 1 << AVG_LOG2;
   localparam int LAT      = NS * (2 * ADC_BITS + 2) * CLK_DIV + 1;
   localparam int LAT0     = (2 * ADC_BITS + 2) * CLK_DIV + 1;
   localparam int WIN      = (2 * ADC_BITS + 1) * CLK_DIV;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [ADC_BITS-1:0] setpoint = '0;
   logic adc_sdo = 1'b0;
   logic adc_cs_n, adc_sclk, error_valid, sat, busy;
   logic signed [8:0] error_output;

   logic start0 = 1'b0;
   logic [ADC_BITS-1:0] setpoint0 = '0;
   logic adc_sdo0 = 1'b0;
   logic adc_cs_n0, adc_sclk0, error_valid0, sat0, busy0;
   logic signed [8:0] error_output0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   laser_error_frontend #(.ADC_BITS(ADC_BITS), .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2)) u_dut (
      .clk(clk), .reset(reset), .start(start), .setpoint(setpoint), .adc_sdo(adc_sdo),
      .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .error_output(error_output),
      .error_valid(error_valid), .sat(sat), .busy(busy));

   laser_error_frontend #(.ADC_BITS(ADC_BITS), .CLK_DIV(CLK_DIV), .AVG_LOG2(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .setpoint(setpoint0), .adc_sdo(adc_sdo0),
      .adc_cs_n(adc_cs_n0), .adc_sclk(adc_sclk0), .error_output(error_output0),
      .error_valid(error_valid0), .sat(sat0), .busy(busy0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: one queued sample per chip-select window, MSB first
   int adc_q[$];
   int win_lens[$];
   int win_rises[$];
   logic [ADC_BITS-1:0] cur_smp = '0;
   int rise_cnt = 0;
   int rise_total = 0;
   int cs_falls = 0;
   time t_fall = 0;

   always @(negedge adc_cs_n) begin
      cur_smp  = (adc_q.size() > 0) ? ADC_BITS'(adc_q.pop_front()) : '0;
      rise_cnt = 0;
      cs_falls++;
      t_fall   = $time;
   end
   always @(posedge adc_cs_n) begin
      win_lens.push_back(int'(($time - t_fall) / 10));
      win_rises.push_back(rise_cnt);
   end
   always @(posedge adc_sclk) begin
      rise_cnt++;
      rise_total++;
   end
   always @(negedge clk)
      adc_sdo = (!adc_cs_n && rise_cnt < ADC_BITS) ? cur_smp[ADC_BITS-1-rise_cnt] : 1'b0;

   logic [ADC_BITS-1:0] smp0 = '0;
   int rise0 = 0;
   always @(negedge adc_cs_n0) rise0 = 0;
   always @(posedge adc_sclk0) rise0++;
   always @(negedge clk)
      adc_sdo0 = (!adc_cs_n0 && rise0 < ADC_BITS) ? smp0[ADC_BITS-1-rise0] : 1'b0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: integer mean of the samples, setpoint minus mean, clamp to 9-bit signed
   function automatic int ref_err(input int sp, input int smp[$], output bit s);
      int sum = 0;
      int d;
      foreach (smp[i]) sum += smp[i];
      d = sp - sum / smp.size();
      s = (d > 255) || (d < -256);
      if (d > 255) return 255;
      if (d < -256) return -256;
      return d;
   endfunction

   function automatic int near(input int sp);
      int v = sp + int'($urandom_range(0, 800)) - 400;
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      return v;
   endfunction

   task automatic check_windows(input string tag, input int nwin);
      int bad = 0;
      foreach (win_lens[i]) if (win_lens[i] != WIN || win_rises[i] != ADC_BITS) bad++;
      chk({tag, "_nwin"}, win_lens.size(), nwin);
      chk({tag, "_badwin"}, bad, 0);
   endtask

   task automatic do_word(input string tag, input int sp, input int s0, input int s1,
                          input int s2, input int s3, input bit pulses);
      int q[$];
      int exp_e, obs_e, nval, lat, t_acc, r0;
      bit exp_s;
      logic obs_s, busy_at, busy_after, busy_early;
      q = '{s0, s1, s2, s3};
      foreach (q[i]) adc_q.push_back(q[i]);
      exp_e = ref_err(sp, q, exp_s);
      win_lens.delete();
      win_rises.delete();
      r0 = rise_total;
      nval = 0; lat = -1; obs_e = 0; obs_s = 1'bx;
      busy_at = 1'bx; busy_after = 1'bx; busy_early = 1'bx;
      @(negedge clk);
      setpoint = ADC_BITS'(sp);
      start = 1'b1;
      @(posedge clk);
      #1 t_acc = cyc;
      @(negedge clk);
      start = 1'b0;
      setpoint = ADC_BITS'($urandom);
      busy_early = busy;
      while (cyc - t_acc < LAT + 100) begin
         @(negedge clk);
         start = pulses && ((cyc - t_acc == 10) || (cyc - t_acc == 200));
         if (start) setpoint = ADC_BITS'($urandom);
         if (error_valid === 1'b1) begin
            nval++;
            if (nval == 1) begin
               lat = cyc - t_acc;
               obs_e = int'(error_output);
               obs_s = sat;
               busy_at = busy;
            end
         end
         if (nval >= 1 && cyc - t_acc == lat + 1) busy_after = busy;
      end
      start = 1'b0;
      chk({tag, "_nvalid"}, nval, 1);
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_err"}, obs_e, exp_e);
      chk({tag, "_sat"}, 32'(obs_s), 32'(exp_s));
      chk({tag, "_err_hold"}, int'(error_output), exp_e);
      chk({tag, "_busy_start"}, 32'(busy_early), 1);
      chk({tag, "_busy_strobe"}, 32'(busy_at), 1);
      chk({tag, "_busy_drop"}, 32'(busy_after), 0);
      chk({tag, "_rises"}, rise_total - r0, NS * ADC_BITS);
      check_windows(tag, NS);
   endtask

   initial begin
      int sp, base, guard, t_acc, nval, lat0;
      int times[$];
      int errs[$];
      int exps[$];
      int q[$];
      int w[4];
      bit es;

      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(adc_cs_n), 1);
      chk("rst_sclk", 32'(adc_sclk), 0);
      chk("rst_err", int'(error_output), 0);
      chk("rst_valid", 32'(error_valid), 0);
      chk("rst_sat", 32'(sat), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      adc_q.delete();
      repeat (2) @(negedge clk);

      do_word("flat", 2048, 2048, 2048, 2048, 2048, 1'b0);
      do_word("low", 2048, 2000, 2000, 2000, 2000, 1'b0);
      do_word("high", 2048, 2200, 2200, 2200, 2200, 1'b0);
      do_word("sat_pos", 2048, 1000, 1000, 1000, 1000, 1'b0);
      do_word("sat_neg", 0, 4095, 4095, 4095, 4095, 1'b0);
      do_word("sat_clear", 2048, 2040, 2050, 2060, 2070, 1'b0);
      do_word("trunc", 100, 100, 101, 102, 103, 1'b0);
      do_word("ignore_start", 3000, 2990, 2991, 2992, 2993, 1'b1);

      for (int k = 0; k < 6; k++) begin
         sp = int'($urandom_range(0, 4095));
         do_word($sformatf("rnd%0d", k), sp, near(sp), near(sp), near(sp), near(sp), 1'b0);
      end

      // Abort a conversion in the 5th bit of the 2nd sample
      do_word("pre_rst", 2048, 2000, 2000, 2000, 2000, 1'b0);
      adc_q = '{555, 666, 777, 888};
      base = cs_falls;
      @(negedge clk);
      setpoint = 12'd700;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!(cs_falls - base == 2 && rise_cnt == 4 && adc_sclk == 1'b0) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("rst_reach_bit5", 32'(guard < 2000), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_cs_n", 32'(adc_cs_n), 1);
      chk("mid_rst_sclk", 32'(adc_sclk), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_err", int'(error_output), 0);
      chk("mid_rst_valid", 32'(error_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      adc_q.delete();
      @(negedge clk);
      do_word("post_rst", 1234, 1300, 1310, 1320, 1330, 1'b0);

      // Start held high: three back-to-back words
      adc_q.delete();
      win_lens.delete();
      win_rises.delete();
      sp = 2000;
      for (int k = 0; k < 3; k++) begin
         foreach (w[i]) w[i] = near(sp);
         q = '{w[0], w[1], w[2], w[3]};
         foreach (q[i]) adc_q.push_back(q[i]);
         exps.push_back(ref_err(sp, q, es));
      end
      @(negedge clk);
      setpoint = ADC_BITS'(sp);
      start = 1'b1;
      @(posedge clk);
      #1 t_acc = cyc;
      while (cyc - t_acc < 3 * LAT + 100) begin
         @(negedge clk);
         if (error_valid === 1'b1) begin
            times.push_back(cyc - t_acc);
            errs.push_back(int'(error_output));
            if (times.size() == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("hold_nvalid", times.size(), 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold_t%0d", k), (times.size() > k) ? times[k] : -1, LAT + k * (LAT + 1));
         chk($sformatf("hold_err%0d", k), (errs.size() > k) ? errs[k] : 9999, exps[k]);
      end
      check_windows("hold", 3 * NS);

      // Single-sample instance: no averaging
      for (int k = 0; k < 2; k++) begin
         int s0v, sp0v, exp0;
         bit es0;
         s0v  = (k == 0) ? 103 : int'($urandom_range(0, 4095));
         sp0v = (k == 0) ? 100 : int'($urandom_range(0, 4095));
         q = '{s0v};
         exp0 = ref_err(sp0v, q, es0);
         smp0 = ADC_BITS'(s0v);
         @(negedge clk);
         setpoint0 = ADC_BITS'(sp0v);
         start0 = 1'b1;
         @(posedge clk);
         #1 t_acc = cyc;
         @(negedge clk);
         start0 = 1'b0;
         nval = 0;
         lat0 = -1;
         while (cyc - t_acc < LAT0 + 40) begin
            @(negedge clk);
            if (error_valid0 === 1'b1) begin
               nval++;
               lat0 = cyc - t_acc;
               chk($sformatf("avg0_err%0d", k), int'(error_output0), exp0);
               chk($sformatf("avg0_sat%0d", k), 32'(sat0), 32'(es0));
            end
         end
         chk($sformatf("avg0_nvalid%0d", k), nval, 1);
         chk($sformatf("avg0_latency%0d", k), lat0, LAT0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/laser_error_frontend.md
Name: laser_error_frontend

Overview:
Measurement front end for the laser power loop. It drives a serial ADC that digitises the photodiode, averages 2^AVG_LOG2 samples, and subtracts the mean from a setpoint. It then saturates the result into the 9-bit signed error word consumed by the PI controller. It is the sensing end of the loop: the PI controller turns error into drive signal, and this block turns the measured plant output back into error.

Parameters:
ADC_BITS, 12, ADC sample width (unsigned, MSB-first serial)
CLK_DIV, 4, clk cycles per adc_sclk half-period (>=2)
AVG_LOG2, 2, log2 of samples averaged per error word (0..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clock clk
start  input  1  request one error word; sampled only in IDLE
setpoint  input  ADC_BITS  unsigned target level; latched on accepted start
adc_sdo  input  1  ADC serial data, MSB first
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock, idle low
error_output  output  9 signed  setpoint minus averaged sample, saturated
error_valid  output  1  one-cycle strobe: error_output updated
sat  output  1  error_output was clipped; valid with error_valid, held until next update
busy  output  1  high from accepted start until the cycle error_valid is asserted (inclusive)

Behaviour:
- Reset values:
  - adc_cs_n=1, adc_sclk=0, error_output=0, error_valid=0, sat=0, busy=0.
  - FSM=IDLE; accumulator, bit counter and sample counter cleared.
- FSM states and transitions:
  - IDLE: start=1 -> latch setpoint, clear accumulator, busy=1, go to SETUP.
  - SETUP: adc_cs_n=0, adc_sclk=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: ADC_BITS full sclk periods, each CLK_DIV low then CLK_DIV high, starting with the low phase after SETUP.
    - adc_sdo is captured into the shift register on the clk edge that drives adc_sclk 0->1.
    - After the last high phase: adc_sclk=0, adc_cs_n=1, sample added to the accumulator, go to GAP.
  - GAP: adc_cs_n=1 for CLK_DIV cycles. If the sample count < 2^AVG_LOG2, go to SETUP; otherwise go to CALC.
  - CALC (1 cycle):
    - mean = accumulator >> AVG_LOG2 (truncate).
    - diff = setpoint - mean, computed signed at ADC_BITS+1 bits.
    - error_output = clamp(diff, -256, +255); sat=1 iff clamped.
    - error_valid=1 for this cycle only; go to IDLE. busy drops the next cycle.
- Accumulator width: ADC_BITS+AVG_LOG2, no overflow possible.
- Latency: error_valid is asserted exactly 2^AVG_LOG2*(2*ADC_BITS+2)*CLK_DIV+1 clk edges after the edge that accepted start. Defaults: 417.
- Start handling:
  - start while busy is ignored, not queued.
  - start held high continuously gives back-to-back conversions: a new start is accepted in the IDLE cycle following CALC.
  - setpoint changes while busy have no effect on the current word.
- error_output and sat hold their value between updates.
- Reset mid-operation (any state): next cycle adc_cs_n=1, adc_sclk=0, busy=0, FSM=IDLE, no error_valid. The partial accumulation is discarded and error_output is cleared to 0.
- adc_sclk never glitches. The sclk and cs_n outputs are registered.

Test Plan:
- Defaults, setpoint=2048, ADC model returns 2048 every sample, one start pulse -> exactly one error_valid at edge 417; error_output=0, sat=0; 48 sclk rising edges, 4 cs_n low windows of 26*4-4=100 cycles.
- setpoint=2048, ADC returns 2000 -> error_output=+48, sat=0. ADC returns 2200 -> error_output=-152, sat=0.
- Saturation:
  - setpoint=2048, ADC returns 1000 -> error_output=+255, sat=1.
  - setpoint=0, ADC returns 4095 -> error_output=-256, sat=1.
  - A following in-range word clears sat.
- Averaging/truncation: setpoint=100, ADC returns 100,101,102,103 -> mean=101, error_output=-1; with AVG_LOG2=0 and sample 103 -> -3.
- Reset asserted during the 5th SHIFT bit of sample 2 -> next cycle cs_n=1, sclk=0, busy=0, error_output=0, no strobe. A new start then yields the correct value at latency 417.
- start pulsed at cycles 10 and 200 while busy -> only one error_valid. start held high for 3 words -> strobes at 417, 835, 1253; no cs_n overlap.
